// File: rtl/reg_file_pkg.sv
// reg_file_pkg: FSM state type and sizing helper shared by the register file blocks
package reg_file_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  function automatic int depth_of(int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read, write-back, issue, clear and debug signals of the register file
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     clr_req;
  logic                     clr_busy;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req, dbg_addr,
    input  rd_data, rd_ready, clr_busy, dbg_data
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req, dbg_addr,
    output rd_data, rd_ready, clr_busy, dbg_data
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register pending bits and read-port ready generation
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     clr,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        hit,
  output logic [NUM_RD-1:0]        ready
);
  localparam int DEPTH = depth_of(ADDR_W);
  logic [DEPTH-1:0] pending, pend_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= pend_nxt;
  // issue is applied after write-back clears so a new producer keeps the bit set
  always_comb begin
    pend_nxt = pending;
    for (int j = 0; j < NUM_WR; j++)
      if (we[j]) pend_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    if (iss) pend_nxt[iss_addr] = 1'b1;
    if (clr) pend_nxt[clr_addr] = 1'b0;
  end
  always_comb begin
    ready = '0;
    for (int k = 0; k < NUM_RD; k++)
      ready[k] = !pending[rd_addr[k*ADDR_W +: ADDR_W]] | hit[k];
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with write-through bypass, pending scoreboard
// and a sequential soft-clear of every register
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int ZERO_R0 = 1
) (
  input logic         clk,
  input logic         SYS_reset_n,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  state_t state, state_nxt;
  logic [ADDR_W:0] cnt, cnt_nxt;
  logic busy, iss;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] we;
  logic [DATA_W-1:0] rd_d [NUM_RD];
  logic [NUM_RD-1:0] hit;
  // r0 writes and issues are discarded here, so r0 never bypasses nor goes pending
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa[j] = bus.wr_addr[j*ADDR_W +: ADDR_W];
    assign wd[j] = bus.wr_data[j*DATA_W +: DATA_W];
    assign we[j] = SYS_reset_n && !busy && bus.wr_en[j] && !(ZERO_R0 != 0 && wa[j] == '0);
  end
  assign iss = SYS_reset_n && !busy && bus.iss_en && !(ZERO_R0 != 0 && bus.iss_addr == '0);
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign bus.rd_data[k*DATA_W +: DATA_W] = rd_d[k];
  end
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_d[k] = mem[bus.rd_addr[k*ADDR_W +: ADDR_W]];
      for (int j = 0; j < NUM_WR; j++)
        if (we[j] && wa[j] == bus.rd_addr[k*ADDR_W +: ADDR_W]) begin
          hit[k] = 1'b1;
          rd_d[k] = wd[j];
        end
    end
  end
  always_ff @(posedge clk or negedge SYS_reset_n)
    if (!SYS_reset_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == ST_IDLE ? (bus.clr_req ? ST_CLEAR : ST_IDLE)
                                 : (cnt == LAST ? ST_IDLE : ST_CLEAR);
    cnt_nxt = state == ST_CLEAR ? cnt + 1'b1 : '0;
  end
  assign busy = state == ST_CLEAR;
  assign bus.clr_busy = busy;
  assign bus.dbg_data = mem[bus.dbg_addr];
  // later write ports overwrite earlier ones on an address collision
  always_ff @(posedge clk or negedge SYS_reset_n)
    if (!SYS_reset_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (busy) mem[cnt[ADDR_W-1:0]] <= '0;
      else for (int j = 0; j < NUM_WR; j++) if (we[j]) mem[wa[j]] <= wd[j];
    end
  reg_file_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) u_sb (
    .clk(clk),
    .rst_n(SYS_reset_n),
    .we(we),
    .wr_addr(bus.wr_addr),
    .iss(iss),
    .iss_addr(bus.iss_addr),
    .clr(busy),
    .clr_addr(cnt[ADDR_W-1:0]),
    .rd_addr(bus.rd_addr),
    .hit(hit),
    .ready(bus.rd_ready)
  );
endmodule
